// File: rtl/ps2_keyboard_ctrl_if.sv
// Read side of the PS/2 scan-code FIFO: head byte, occupancy and valid/ready pop handshake.
interface ps2_keyboard_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] fifo_count;

  modport master (output rd_data, rd_valid, fifo_count, input rd_ready);
  modport slave  (input rd_data, rd_valid, fifo_count, output rd_ready);
endinterface

// File: rtl/ps2_keyboard_ctrl.sv
// Receive-only PS/2 keyboard controller: pin conditioning, 11-bit frame FSM with
// parity/stop/timeout checks, and a first-word-fall-through scan-code FIFO.
module ps2_keyboard_ctrl #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 32000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_keyboard_ctrl_if.master rd,
  output logic                overflow,
  input  logic                clear_err,
  output logic                parity_err,
  output logic                frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  // ---------------- input conditioning ----------------
  logic [1:0]            clk_sync, dat_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt, clk_filt_d;
  logic                  strobe, ps2_bit;

  // Everything resets high so reset release looks like an idle bus.
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      clk_hist   <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      clk_hist   <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      if (&clk_hist)       clk_filt <= 1'b1;
      else if (~|clk_hist) clk_filt <= 1'b0;
      clk_filt_d <= clk_filt;
    end
  end

  assign strobe  = clk_filt_d & ~clk_filt;
  assign ps2_bit = dat_sync[1];

  // ---------------- frame FSM ----------------
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tmo;
  logic          push;
  logic [7:0]    push_byte;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      tmo        <= '0;
      push       <= 1'b0;
      push_byte  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      push       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        tmo <= '0;
        if (strobe && !ps2_bit) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (strobe) begin
        tmo <= '0;
        case (state)
          DATA: begin
            shreg   <= {ps2_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, ps2_bit};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // A bad stop bit masks any parity problem in the same frame.
            if (!ps2_bit)     frame_err  <= 1'b1;
            else if (!par_ok) parity_err <= 1'b1;
            else begin
              push      <= 1'b1;
              push_byte <= shreg;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        shreg     <= '0;
        tmo       <= '0;
      end else begin
        tmo <= tmo + 1'b1;
      end
    end
  end

  // ---------------- scan-code FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, do_push;

  assign pop     = rd.rd_valid & rd.rd_ready;
  assign full    = (count == CW'(FIFO_DEPTH));
  // When full, a simultaneous pop frees the slot the new byte needs.
  assign do_push = push & (~full | pop);

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_err)       overflow <= 1'b0;
    end
  end

  assign rd.rd_valid   = (count != '0);
  assign rd.rd_data    = mem[rd_ptr];
  assign rd.fifo_count = count;
endmodule
